// File: rtl/router_src_arb.sv
// Packet-level round-robin arbiter placing three byte sources onto the single
// router input; malformed packets are drained from the source and dropped.
module router_src_arb (
  input  logic       clock,
  input  logic       resetn,
  input  logic [2:0] src_valid,
  input  logic [7:0] src_data_0,
  input  logic [7:0] src_data_1,
  input  logic [7:0] src_data_2,
  output logic [2:0] src_ready,
  input  logic       rtr_busy,
  output logic       rtr_pkt_valid,
  output logic [7:0] rtr_data,
  output logic [2:0] grant,
  output logic       drop_pulse,
  output logic       proto_err
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PARITY  = 3'd3,
    ST_DROP    = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [5:0]  rem_r;
  logic [1:0]  last_r;
  logic [6:0]  drop_left_r;

  logic [2:0]  pick_s;
  logic        pick_found_s;
  logic [1:0]  pick_idx_s;
  logic [7:0]  pick_data_s;
  logic [5:0]  pick_len_s;
  logic        pick_bad_s;
  logic [7:0]  g_data_s;
  logic        g_valid_s;
  logic        active_s;
  logic        ready_g_s;
  logic        xfer_s;

  // {found, index}: first requester in the order last+1, last+2, last (mod 3)
  function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
    logic [3:0] req_ext;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] c3;
    req_ext = {1'b0, req};
    c1 = (last >= 2'd2) ? 2'd0 : last + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    c3 = (c2 == 2'd2) ? 2'd0 : c2 + 2'd1;
    if (req_ext[c1]) begin
      return {1'b1, c1};
    end else if (req_ext[c2]) begin
      return {1'b1, c2};
    end else if (req_ext[c3]) begin
      return {1'b1, c3};
    end else begin
      return 3'b000;
    end
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] src_byte(input logic [1:0] idx, input logic [7:0] d0,
                                          input logic [7:0] d1, input logic [7:0] d2);
    case (idx)
      2'd0:    return d0;
      2'd1:    return d1;
      2'd2:    return d2;
      default: return 8'h00;
    endcase
  endfunction

  // Arbitration, header decode and granted-source datapath
  always_comb begin
    logic [1:0] g_idx;
    pick_s       = rr_pick(last_r, src_valid);
    pick_found_s = pick_s[2];
    pick_idx_s   = pick_s[1:0];
    pick_data_s  = src_byte(pick_idx_s, src_data_0, src_data_1, src_data_2);
    pick_len_s   = pick_data_s[7:2];
    pick_bad_s   = (pick_data_s[1:0] == 2'd3) || (pick_len_s == 6'd0);
    case (grant)
      3'b001:  g_idx = 2'd0;
      3'b010:  g_idx = 2'd1;
      3'b100:  g_idx = 2'd2;
      default: g_idx = 2'd3;
    endcase
    g_data_s  = src_byte(g_idx, src_data_0, src_data_1, src_data_2);
    g_valid_s = |(grant & src_valid);
    active_s  = (state_r == ST_HEADER) || (state_r == ST_PAYLOAD) || (state_r == ST_PARITY);
    ready_g_s = (active_s && !rtr_busy) || (state_r == ST_DROP);
    xfer_s    = ready_g_s && g_valid_s;
  end

  // State register
  always_ff @(posedge clock) begin
    if (resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; every move past IDLE waits for a real handshake
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_nxt_s = pick_bad_s ? ST_DROP : ST_HEADER;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HEADER:  state_nxt_s = xfer_s ? ST_PAYLOAD : ST_HEADER;
      ST_PAYLOAD: state_nxt_s = (xfer_s && (rem_r == 6'd1)) ? ST_PARITY : ST_PAYLOAD;
      ST_PARITY:  state_nxt_s = xfer_s ? ST_IDLE : ST_PARITY;
      ST_DROP:    state_nxt_s = (xfer_s && (drop_left_r == 7'd1)) ? ST_IDLE : ST_DROP;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Router-side and source-side handshake outputs
  always_comb begin
    src_ready     = ready_g_s ? grant : 3'b000;
    rtr_pkt_valid = (state_r == ST_HEADER) || (state_r == ST_PAYLOAD);
    rtr_data      = active_s ? g_data_s : 8'h00;
  end

  // Grant, counters, round-robin pointer and status flags
  always_ff @(posedge clock) begin
    if (resetn) begin
      rem_r       <= 6'd0;
      last_r      <= 2'd2;
      grant       <= 3'b000;
      drop_left_r <= 7'd0;
      drop_pulse  <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      if ((state_r != ST_IDLE) && !g_valid_s) begin
        proto_err <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            grant       <= onehot3(pick_idx_s);
            rem_r       <= pick_len_s;
            last_r      <= pick_idx_s;
            drop_left_r <= {1'b0, pick_len_s} + 7'd2;
          end
        end
        ST_PAYLOAD: begin
          if (xfer_s) begin
            rem_r <= rem_r - 6'd1;
          end
        end
        ST_PARITY: begin
          if (xfer_s) begin
            grant <= 3'b000;
          end
        end
        ST_DROP: begin
          if (xfer_s) begin
            drop_left_r <= drop_left_r - 7'd1;
            if (drop_left_r == 7'd1) begin
              grant      <= 3'b000;
              drop_pulse <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_router_src_arb.sv
// Directed bench for router_src_arb: source byte queues feed the DUT and a
// negedge monitor checks every accepted byte against a scoreboard queue.
module tb_router_src_arb;

  logic       clock = 1'b0;
  logic       resetn;
  logic [2:0] src_valid;
  logic [7:0] src_data_0, src_data_1, src_data_2;
  logic [2:0] src_ready;
  logic       rtr_busy;
  logic       rtr_pkt_valid;
  logic [7:0] rtr_data;
  logic [2:0] grant;
  logic       drop_pulse;
  logic       proto_err;

  router_src_arb dut (
    .clock(clock), .resetn(resetn), .src_valid(src_valid),
    .src_data_0(src_data_0), .src_data_1(src_data_1), .src_data_2(src_data_2),
    .src_ready(src_ready), .rtr_busy(rtr_busy), .rtr_pkt_valid(rtr_pkt_valid),
    .rtr_data(rtr_data), .grant(grant), .drop_pulse(drop_pulse), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] g;
    logic       pv;
    logic [7:0] d;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] q0[$], q1[$], q2[$];
  logic [2:0] gap_mask = 3'b000;
  logic [2:0] hs_r = 3'b000;
  logic       mon_en = 1'b0;
  logic       pend = 1'b0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         drop_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic update_srcs();
    src_valid[0] = (q0.size() > 0) && !gap_mask[0];
    src_valid[1] = (q1.size() > 0) && !gap_mask[1];
    src_valid[2] = (q2.size() > 0) && !gap_mask[2];
    src_data_0   = (q0.size() > 0) ? q0[0] : 8'h00;
    src_data_1   = (q1.size() > 0) ? q1[0] : 8'h00;
    src_data_2   = (q2.size() > 0) ? q2[0] : 8'h00;
  endtask

  // Source side: a byte leaves its queue after the edge that accepted it
  always @(negedge clock) hs_r = src_valid & src_ready;

  always @(posedge clock) begin
    #1;
    if (hs_r[0] && q0.size() > 0) void'(q0.pop_front());
    if (hs_r[1] && q1.size() > 0) void'(q1.pop_front());
    if (hs_r[2] && q2.size() > 0) void'(q2.pop_front());
    update_srcs();
  end

  // Monitor: every accepted source byte must match the next expected transfer
  always @(negedge clock) begin : mon
    logic [2:0] hs;
    exp_t       e;
    if (mon_en) begin
      hs = src_valid & src_ready;
      if (pend || drop_pulse) check("drop_pulse", {31'd0, drop_pulse}, {31'd0, pend});
      if (drop_pulse) drop_cnt++;
      pend = 1'b0;
      if (hs != 3'b000) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL xfer: unexpected handshake ready=%b grant=%b data=%h", src_ready, grant, rtr_data);
        end else begin
          e = exp_q.pop_front();
          check("xfer {grant,pkt_valid,data}", {20'd0, grant, rtr_pkt_valid, rtr_data},
                {20'd0, e.g, e.pv, e.d});
          pend = e.last;
        end
      end
    end
  end

  // Loads a packet into a source queue and the first n_exp transfers into the scoreboard
  task automatic push_pkt(input int src, input logic [7:0] hdr, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                          input logic [7:0] par, input int n_exp);
    logic [7:0] bytes[$];
    logic [7:0] pl[4];
    logic       drop;
    logic [2:0] g;
    int         len;
    exp_t       e;
    len  = int'(hdr[7:2]);
    drop = (hdr[1:0] == 2'd3) || (len == 0);
    g    = 3'b001 << src;
    pl[0] = b0; pl[1] = b1; pl[2] = b2; pl[3] = b3;
    bytes.push_back(hdr);
    for (int i = 0; i < len && i < 4; i++) bytes.push_back(pl[i]);
    bytes.push_back(par);
    for (int i = 0; i < bytes.size(); i++) begin
      case (src)
        0:       q0.push_back(bytes[i]);
        1:       q1.push_back(bytes[i]);
        default: q2.push_back(bytes[i]);
      endcase
      if (i < n_exp) begin
        e.g    = g;
        e.pv   = !drop && (i != bytes.size() - 1);
        e.d    = drop ? 8'h00 : bytes[i];
        e.last = drop && (i == bytes.size() - 1);
        exp_q.push_back(e);
      end
    end
    update_srcs();
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0 || q2.size() != 0) && k < 400) begin
      tick();
      k++;
    end
    if (k >= 400) begin
      n_chk++;
      $display("FAIL timeout: %0d expected transfers still pending", exp_q.size());
    end
    tick();
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"}, {29'd0, grant}, 32'd0);
    check({tag, "_pkt_valid"}, {31'd0, rtr_pkt_valid}, 32'd0);
    check({tag, "_data"}, {24'd0, rtr_data}, 32'd0);
    check({tag, "_src_ready"}, {29'd0, src_ready}, 32'd0);
    check({tag, "_drop_pulse"}, {31'd0, drop_pulse}, 32'd0);
    check({tag, "_proto_err"}, {31'd0, proto_err}, 32'd0);
  endtask

  initial begin
    int cnt;
    resetn   = 1'b1;
    rtr_busy = 1'b0;
    update_srcs();
    repeat (2) tick();
    resetn = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);
    check_reset_vals("reset");

    // Round-robin: all sources request, source 0 holding two packets
    tick();
    push_pkt(0, 8'h04, 8'h10, 8'h00, 8'h00, 8'h00, 8'h1F, 99);
    push_pkt(1, 8'h05, 8'h20, 8'h00, 8'h00, 8'h00, 8'h2F, 99);
    push_pkt(2, 8'h06, 8'h30, 8'h00, 8'h00, 8'h00, 8'h3F, 99);
    push_pkt(0, 8'h08, 8'h13, 8'h14, 8'h00, 8'h00, 8'h1E, 99);
    wait_idle();

    // Single packet from source 1: IDLE cycle plus four granted cycles
    push_pkt(1, 8'h09, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'hC5, 99);
    @(negedge clock);
    check("single_idle_grant", {29'd0, grant}, 32'd0);
    tick();
    @(negedge clock);
    check("single_grant", {29'd0, grant}, 32'd2);
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      @(negedge clock);
      if (grant == 3'b000) break;
      cnt++;
    end
    check("single_granted_cycles", cnt, 32'd4);
    wait_idle();

    // Busy stall for three cycles while payload byte 22 is presented
    push_pkt(0, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 99);
    tick(); tick(); tick();
    rtr_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("busy_src_ready", {29'd0, src_ready}, 32'd0);
      check("busy_data", {24'd0, rtr_data}, 32'h22);
      check("busy_pkt_valid", {31'd0, rtr_pkt_valid}, 32'd1);
      tick();
    end
    rtr_busy = 1'b0;
    wait_idle();

    // Drops: dest 3 with length 2, then length 0
    push_pkt(2, 8'h0B, 8'h01, 8'h02, 8'h00, 8'h00, 8'h03, 99);
    wait_idle();
    check("drop_count_dest3", drop_cnt, 32'd1);
    push_pkt(0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7E, 99);
    wait_idle();
    check("drop_count_len0", drop_cnt, 32'd2);

    // One-cycle valid gap mid-payload
    push_pkt(0, 8'h0C, 8'h5A, 8'h5B, 8'h5C, 8'h00, 8'h5D, 99);
    tick(); tick(); tick();
    gap_mask = 3'b001;
    update_srcs();
    @(negedge clock);
    check("gap_proto_err_before", {31'd0, proto_err}, 32'd0);
    tick();
    gap_mask = 3'b000;
    update_srcs();
    @(negedge clock);
    check("gap_proto_err_set", {31'd0, proto_err}, 32'd1);
    wait_idle();
    check("gap_proto_err_sticky", {31'd0, proto_err}, 32'd1);

    // Reset mid-payload; afterwards source 0 beats source 2
    push_pkt(1, 8'h0D, 8'h61, 8'h62, 8'h63, 8'h00, 8'h64, 2);
    tick(); tick(); tick();
    resetn = 1'b1;
    q1.delete();
    update_srcs();
    tick();
    resetn = 1'b0;
    push_pkt(0, 8'h04, 8'h81, 8'h00, 8'h00, 8'h00, 8'h8F, 99);
    push_pkt(2, 8'h06, 8'h71, 8'h00, 8'h00, 8'h00, 8'h7F, 99);
    @(negedge clock);
    check_reset_vals("midreset");
    tick();
    @(negedge clock);
    check("after_reset_grant", {29'd0, grant}, 32'd1);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
